// File: rtl/ct_arb.sv
// ct_arb: two-requester round-robin arbiter with lock, sharing one synchronous ct_mem read port.
// Latency: grant is combinational in the request cycle; read data returns MEM_LAT+1 clocks after the grant edge.
// Backpressure: a requester holds req until it sees gnt; the loser, or the non-owner while a lock is held, waits.
//
// Ports:
//   clk, rst                  rising-edge clock, asynchronous active-high reset
//   req0/1, addr0/1, lock0/1  per-requester read request, address, and ownership lock
//   gnt0/1                    combinational accept of the current request
//   rddata0/1, valid0/1       registered read data and its one-cycle strobe
//   mem_addr, mem_rddata      shared ct_mem port (address out, q in)
module ct_arb #(
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic          lock0,
    input  logic          lock1,
    output logic          gnt0,
    output logic          gnt1,
    output logic [DW-1:0] rddata0,
    output logic [DW-1:0] rddata1,
    output logic          valid0,
    output logic          valid1,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_rddata
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t        state;
    logic          last;        // requester granted most recently; the other wins a tie
    logic [AW-1:0] addr_q;      // mem_addr value held between grants
    logic          own0_act;
    logic          own1_act;

    // Tag pipeline: one slot per memory latency stage
    logic [MEM_LAT-1:0] tag_live;
    logic [MEM_LAT-1:0] tag_id;

    // Ownership only binds while the owner keeps its lock high; a low lock
    // drops straight back to round-robin in the same cycle.
    assign own0_act = (state == OWN0) && lock0;
    assign own1_act = (state == OWN1) && lock1;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end else if (own0_act) begin
            gnt0 = req0;
        end else if (own1_act) begin
            gnt1 = req1;
        end else if (req0 && req1) begin
            gnt0 = last;
            gnt1 = !last;
        end else begin
            gnt0 = req0;
            gnt1 = req1;
        end
    end

    // The memory samples mem_addr on the edge closing the grant cycle, so the
    // granted address must be presented combinationally.
    always_comb begin
        mem_addr = addr_q;
        if (gnt0) begin
            mem_addr = addr0;
        end else if (gnt1) begin
            mem_addr = addr1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            last   <= 1'b1;
            addr_q <= '0;
        end else begin
            addr_q <= mem_addr;
            if (gnt0) begin
                last  <= 1'b0;
                state <= lock0 ? OWN0 : IDLE;
            end else if (gnt1) begin
                last  <= 1'b1;
                state <= lock1 ? OWN1 : IDLE;
            end else if ((state == OWN0 && !lock0) || (state == OWN1 && !lock1)) begin
                state <= IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_live <= '0;
            tag_id   <= '0;
        end else begin
            tag_live[0] <= gnt0 || gnt1;
            tag_id[0]   <= gnt1;
            for (int k = 1; k < MEM_LAT; k++) begin
                tag_live[k] <= tag_live[k-1];
                tag_id[k]   <= tag_id[k-1];
            end
        end
    end

    // A live tag leaving the pipeline lines up with mem_rddata for its address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rddata0 <= '0;
            rddata1 <= '0;
            valid0  <= 1'b0;
            valid1  <= 1'b0;
        end else begin
            valid0 <= 1'b0;
            valid1 <= 1'b0;
            if (tag_live[MEM_LAT-1]) begin
                if (tag_id[MEM_LAT-1]) begin
                    rddata1 <= mem_rddata;
                    valid1  <= 1'b1;
                end else begin
                    rddata0 <= mem_rddata;
                    valid0  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ct_arb.sv
// tb_ct_arb: self-checking bench for ct_arb with a latency-accurate memory model.
// Latency: expects valid exactly LAT+1 clocks after each grant, data from the model memory.
// Backpressure: stimulus holds req until grant, with occasional cancels in the random phase.
module tb_ct_arb;

    localparam int AW  = 8;
    localparam int DW  = 8;
    localparam int LAT = 1;

    logic          clk;
    logic          rst;
    logic          req0, req1, lock0, lock1;
    logic [AW-1:0] addr0, addr1;
    logic          gnt0, gnt1, valid0, valid1;
    logic [DW-1:0] rddata0, rddata1;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rddata;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    ct_arb #(.AW(AW), .DW(DW), .MEM_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1),
        .addr0(addr0), .addr1(addr1),
        .lock0(lock0), .lock1(lock1),
        .gnt0(gnt0), .gnt1(gnt1),
        .rddata0(rddata0), .rddata1(rddata1),
        .valid0(valid0), .valid1(valid1),
        .mem_addr(mem_addr), .mem_rddata(mem_rddata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
        return 8'((a * 8'd7) ^ 8'h5A);
    endfunction

    // Synchronous memory: samples mem_addr each edge, q appears LAT edges later
    logic [DW-1:0] mq [LAT];
    always @(posedge clk) begin
        mq[0] <= memf(mem_addr);
        for (int k = 1; k < LAT; k++) mq[k] <= mq[k-1];
    end
    assign mem_rddata = mq[LAT-1];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Scoreboard: expected data and grant cycle queued on each grant
    typedef struct {
        logic [DW-1:0] data;
        int            gcyc;
    } exp_t;

    exp_t          q0[$];
    exp_t          q1[$];
    exp_t          e;
    int            ngnt0 = 0, ngnt1 = 0, nval0 = 0, nval1 = 0;
    logic [AW-1:0] prev_ma = '0;

    always @(negedge clk) begin
        if (rst) begin
            q0.delete();
            q1.delete();
            ngnt0 = 0; ngnt1 = 0; nval0 = 0; nval1 = 0;
            prev_ma = '0;
        end else begin
            chk("mutex", {31'd0, gnt0 & gnt1}, 32'd0);
            if (gnt0) begin
                chk("mem_addr0", 32'(mem_addr), 32'(addr0));
                q0.push_back('{memf(addr0), cyc});
                ngnt0++;
            end else if (gnt1) begin
                chk("mem_addr1", 32'(mem_addr), 32'(addr1));
                q1.push_back('{memf(addr1), cyc});
                ngnt1++;
            end else begin
                chk("mem_addr_hold", 32'(mem_addr), 32'(prev_ma));
            end
            prev_ma = mem_addr;
            if (valid0) begin
                nval0++;
                if (q0.size() == 0) begin
                    chk("valid0_unexpected", 32'd1, 32'd0);
                end else begin
                    e = q0.pop_front();
                    chk("rddata0", 32'(rddata0), 32'(e.data));
                    chk("lat0", 32'(cyc - e.gcyc), 32'(LAT + 1));
                end
            end
            if (valid1) begin
                nval1++;
                if (q1.size() == 0) begin
                    chk("valid1_unexpected", 32'd1, 32'd0);
                end else begin
                    e = q1.pop_front();
                    chk("rddata1", 32'(rddata1), 32'(e.data));
                    chk("lat1", 32'(cyc - e.gcyc), 32'(LAT + 1));
                end
            end
        end
    end

    typedef struct {
        logic r0, r1, l0, l1, g0, g1;
    } vec_t;

    vec_t tbl [26];
    logic g0s, g1s;

    initial begin
        // req0 req1 lock0 lock1 -> gnt0 gnt1, applied in order from reset
        tbl[0]  = '{1,1,0,0, 1,0};  // tie after reset: requester 0 first
        tbl[1]  = '{0,1,0,0, 0,1};
        tbl[2]  = '{1,1,0,0, 1,0};  // alternation under contention
        tbl[3]  = '{1,1,0,0, 0,1};
        tbl[4]  = '{1,1,0,0, 1,0};
        tbl[5]  = '{1,1,0,0, 0,1};
        tbl[6]  = '{1,0,0,0, 1,0};  // lone requester, back-to-back
        tbl[7]  = '{1,0,0,0, 1,0};
        tbl[8]  = '{1,1,0,0, 0,1};
        tbl[9]  = '{1,1,1,0, 1,0};  // lock0 held five cycles
        tbl[10] = '{1,1,1,0, 1,0};
        tbl[11] = '{1,1,1,0, 1,0};
        tbl[12] = '{1,1,1,0, 1,0};
        tbl[13] = '{1,1,1,0, 1,0};
        tbl[14] = '{1,1,0,0, 0,1};  // lock drops: req1 served that cycle
        tbl[15] = '{1,0,1,0, 1,0};  // enter OWN0
        tbl[16] = '{0,1,1,0, 0,0};  // req1 blocked by owner
        tbl[17] = '{0,0,1,0, 0,0};  // req1 cancelled
        tbl[18] = '{1,1,0,0, 0,1};  // pointer untouched by the cancel
        tbl[19] = '{1,1,1,0, 1,0};
        tbl[20] = '{0,1,1,1, 0,0};  // lock1 ignored inside OWN0
        tbl[21] = '{0,1,0,1, 0,1};  // OWN0 left, req1 granted and locks
        tbl[22] = '{1,1,0,1, 0,1};
        tbl[23] = '{1,0,0,1, 0,0};
        tbl[24] = '{1,1,0,0, 1,0};
        tbl[25] = '{0,0,0,0, 0,0};

        rst = 1'b1;
        req0 = 0; req1 = 0; lock0 = 0; lock1 = 0;
        addr0 = '0; addr1 = '0;
        repeat (3) @(posedge clk);
        #1 req0 = 1; req1 = 1; addr0 = 8'hAA; addr1 = 8'hBB;
        @(negedge clk);
        chk("reset_outputs", {8'(gnt0), 8'(gnt1), 8'(valid0), 8'(valid1)}, 32'd0);
        chk("reset_data", {8'd0, rddata0, rddata1, mem_addr}, 32'd0);
        @(posedge clk);
        #1 rst = 0; req0 = 0; req1 = 0;

        for (int i = 0; i < 26; i++) begin
            @(posedge clk);
            #1;
            req0  = tbl[i].r0;
            req1  = tbl[i].r1;
            lock0 = tbl[i].l0;
            lock1 = tbl[i].l1;
            addr0 = 8'h10 + 8'(i * 3);
            addr1 = 8'h1B + 8'(i * 5);
            @(negedge clk);
            chk($sformatf("vec%0d_gnt", i), {30'd0, gnt1, gnt0}, {30'd0, tbl[i].g1, tbl[i].g0});
        end
        repeat (4) @(posedge clk);

        // Reset one cycle after gnt1 must discard the in-flight read
        #1 req1 = 1; addr1 = 8'h77;
        @(negedge clk);
        chk("pre_rst_gnt1", {31'd0, gnt1}, 32'd1);
        @(posedge clk);
        #1 rst = 1; req1 = 0; req0 = 1; addr0 = 8'h33;
        @(negedge clk);
        chk("mid_rst_outputs", {8'(gnt0), 8'(gnt1), 8'(valid0), 8'(valid1)}, 32'd0);
        chk("mid_rst_data", {8'd0, rddata0, rddata1, mem_addr}, 32'd0);
        @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("post_rst_gnt0", {30'd0, gnt1, gnt0}, 32'd1);
        @(posedge clk);
        #1 req0 = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_stale_valid1", {31'd0, valid1}, 32'd0);
        end

        // Random traffic with lock, cancels and address churn
        g0s = 0; g1s = 0;
        for (int n = 0; n < 10000; n++) begin
            @(posedge clk);
            #1;
            if (!req0 || g0s) begin
                req0 = 1'($urandom_range(0, 1)); addr0 = 8'($urandom);
            end else if ($urandom_range(0, 15) == 0) begin
                req0 = 0;
            end
            if (!req1 || g1s) begin
                req1 = 1'($urandom_range(0, 1)); addr1 = 8'($urandom);
            end else if ($urandom_range(0, 15) == 0) begin
                req1 = 0;
            end
            lock0 = ($urandom_range(0, 3) == 0);
            lock1 = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            g0s = gnt0; g1s = gnt1;
        end
        @(posedge clk);
        #1 req0 = 0; req1 = 0; lock0 = 0; lock1 = 0;
        repeat (LAT + 4) @(posedge clk);
        @(negedge clk);
        chk("count0", 32'(nval0), 32'(ngnt0));
        chk("count1", 32'(nval1), 32'(ngnt1));
        chk("drained", 32'(q0.size() + q1.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
